// File: rtl/divider_arbiter_if.sv
// Requester-side and divider-side signals of the shared-divider arbiter.
// slave is the arbiter's view; master is the view of the requesters and divider.
interface divider_arbiter_if #(
    parameter int unsigned n        = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned log2nreq = 2
);
    logic [NREQ-1:0]     req;
    logic [NREQ*n-1:0]   dividend_in;
    logic [NREQ*n-1:0]   divisor_in;
    logic [NREQ-1:0]     resp_valid;
    logic [n-1:0]        quotient_out;
    logic [n-1:0]        remainder_out;
    logic                div_by_zero;
    logic                busy;
    logic [log2nreq-1:0] grant_id;
    logic                div_go;
    logic [n-1:0]        div_dividend;
    logic [n-1:0]        div_divisor;
    logic [n-1:0]        div_quotient;
    logic [n-1:0]        div_remainder;
    logic                div_done;

    modport slave (
        input  req, dividend_in, divisor_in,
        input  div_quotient, div_remainder, div_done,
        output resp_valid, quotient_out, remainder_out, div_by_zero, busy, grant_id,
        output div_go, div_dividend, div_divisor
    );

    modport master (
        output req, dividend_in, divisor_in,
        output div_quotient, div_remainder, div_done,
        input  resp_valid, quotient_out, remainder_out, div_by_zero, busy, grant_id,
        input  div_go, div_dividend, div_divisor
    );
endinterface

// File: rtl/divider_arbiter.sv
// Round-robin sharing of one serial go/done divider among NREQ requesters,
// with local divide-by-zero handling and a one-cycle per-requester result strobe.
module divider_arbiter #(
    parameter int unsigned n        = 8,
    parameter int unsigned NREQ     = 4,
    parameter int unsigned log2nreq = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              clken,
    divider_arbiter_if.slave  bus
);
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_GO   = 2'd1,
        S_DROP = 2'd2,
        S_RESP = 2'd3
    } state_t;

    state_t              r_state;
    logic [log2nreq-1:0] r_ptr;
    logic [log2nreq-1:0] r_grant_id;
    logic [NREQ-1:0]     r_resp_valid;
    logic [n-1:0]        r_quotient;
    logic [n-1:0]        r_remainder;
    logic [n-1:0]        r_div_dividend;
    logic [n-1:0]        r_div_divisor;
    logic                r_div_by_zero;
    logic                r_busy;
    logic                r_div_go;

    logic [n-1:0]        w_dvd_arr [NREQ];
    logic [n-1:0]        w_dvs_arr [NREQ];
    logic                w_found;
    logic [log2nreq-1:0] w_winner;
    logic [n-1:0]        w_dividend;
    logic [n-1:0]        w_divisor;

    // Unpack the per-requester operand buses.
    for (genvar k = 0; k < NREQ; k++) begin : g_unpack
        assign w_dvd_arr[k] = bus.dividend_in[k*n +: n];
        assign w_dvs_arr[k] = bus.divisor_in[k*n +: n];
    end

    // First request at or above r_ptr, wrapping modulo NREQ.
    always_comb begin
        w_found  = 1'b0;
        w_winner = '0;
        for (int unsigned i = 0; i < NREQ; i++) begin
            if (!w_found && bus.req[log2nreq'((32'(r_ptr) + i) % NREQ)]) begin
                w_found  = 1'b1;
                w_winner = log2nreq'((32'(r_ptr) + i) % NREQ);
            end
        end
    end

    assign w_dividend = w_dvd_arr[w_winner];
    assign w_divisor  = w_dvs_arr[w_winner];

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state        <= S_IDLE;
            r_ptr          <= '0;
            r_grant_id     <= '0;
            r_resp_valid   <= '0;
            r_quotient     <= '0;
            r_remainder    <= '0;
            r_div_dividend <= '0;
            r_div_divisor  <= '0;
            r_div_by_zero  <= 1'b0;
            r_busy         <= 1'b0;
            r_div_go       <= 1'b0;
        end else if (clken) begin
            case (r_state)
                S_IDLE: begin
                    r_resp_valid <= '0;
                    if (w_found) begin
                        r_grant_id     <= w_winner;
                        r_div_dividend <= w_dividend;
                        r_div_divisor  <= w_divisor;
                        r_busy         <= 1'b1;
                        // Zero divisor is answered locally and skips the divider.
                        if (w_divisor == '0) begin
                            r_quotient    <= '1;
                            r_remainder   <= w_dividend;
                            r_div_by_zero <= 1'b1;
                            r_resp_valid  <= NREQ'(1) << w_winner;
                            r_state       <= S_RESP;
                        end else begin
                            r_div_by_zero <= 1'b0;
                            r_div_go      <= 1'b1;
                            r_state       <= S_GO;
                        end
                    end
                end
                S_GO: begin
                    if (bus.div_done) begin
                        r_quotient  <= bus.div_quotient;
                        r_remainder <= bus.div_remainder;
                        r_div_go    <= 1'b0;
                        r_state     <= S_DROP;
                    end
                end
                S_DROP: begin
                    r_resp_valid <= NREQ'(1) << r_grant_id;
                    r_state      <= S_RESP;
                end
                S_RESP: begin
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_ptr        <= log2nreq'((32'(r_grant_id) + 32'd1) % NREQ);
                    r_state      <= S_IDLE;
                end
                default: begin
                    r_div_go     <= 1'b0;
                    r_resp_valid <= '0;
                    r_busy       <= 1'b0;
                    r_state      <= S_IDLE;
                end
            endcase
        end
    end

    assign bus.resp_valid    = r_resp_valid;
    assign bus.quotient_out  = r_quotient;
    assign bus.remainder_out = r_remainder;
    assign bus.div_by_zero   = r_div_by_zero;
    assign bus.busy          = r_busy;
    assign bus.grant_id      = r_grant_id;
    assign bus.div_go        = r_div_go;
    assign bus.div_dividend  = r_div_dividend;
    assign bus.div_divisor   = r_div_divisor;
endmodule

// File: tb/tb_divider_arbiter.sv
// Self-checking bench for divider_arbiter with a behavioural serial divider
// (done n+1 enabled cycles after go) and a round-robin reference model.
module tb_divider_arbiter;
    localparam int unsigned N    = 8;
    localparam int unsigned NREQ = 4;
    localparam int unsigned LG   = 2;

    logic clk = 1'b0;
    logic reset;
    logic clken;

    always #5 clk = ~clk;

    divider_arbiter_if #(.n(N), .NREQ(NREQ), .log2nreq(LG)) bus();

    divider_arbiter #(.n(N), .NREQ(NREQ), .log2nreq(LG)) dut (
        .clk   (clk),
        .reset (reset),
        .clken (clken),
        .bus   (bus)
    );

    // Behavioural divider: results appear with done after n+1 enabled edges of go.
    int unsigned dcnt;
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            dcnt              <= 0;
            bus.div_done      <= 1'b0;
            bus.div_quotient  <= '0;
            bus.div_remainder <= '0;
        end else if (clken) begin
            if (!bus.div_go) begin
                dcnt         <= 0;
                bus.div_done <= 1'b0;
            end else if (!bus.div_done) begin
                if (dcnt == N) begin
                    bus.div_done      <= 1'b1;
                    bus.div_quotient  <= (bus.div_divisor == 0) ? '1 : bus.div_dividend / bus.div_divisor;
                    bus.div_remainder <= (bus.div_divisor == 0) ? bus.div_dividend : bus.div_dividend % bus.div_divisor;
                end else begin
                    dcnt <= dcnt + 1;
                end
            end
        end
    end

    int n_chk  = 0;
    int n_fail = 0;

    typedef struct {
        int         k;
        logic [7:0] dvd;
        logic [7:0] dvs;
        logic [7:0] q;
        logic [7:0] r;
        logic       dbz;
        int         lat;
        int         go;
    } vec_t;

    vec_t tbl [10];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", nm, act, act, exp, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_op(input int k, input logic [7:0] dvd, input logic [7:0] dvs);
        bus.dividend_in[k*N +: N] = dvd;
        bus.divisor_in[k*N +: N]  = dvs;
    endtask

    // Cycles from the current cycle until resp_valid is seen, with div_go cycle count.
    task automatic wait_resp(output int lat, output int gocnt);
        lat   = 0;
        gocnt = 0;
        do begin
            tick();
            lat++;
            if (bus.div_go === 1'b1) gocnt++;
        end while (bus.resp_valid === '0 && lat < 100);
    endtask

    task automatic check_result(input string nm, input int k, input logic [7:0] q, input logic [7:0] r,
                                input logic dbz, input int exp_lat, input int lat);
        chk({nm, "_lat"},   32'(lat), 32'(exp_lat));
        chk({nm, "_valid"}, 32'(bus.resp_valid), 32'(1) << k);
        chk({nm, "_grant"}, 32'(bus.grant_id), 32'(k));
        chk({nm, "_q"},     32'(bus.quotient_out), 32'(q));
        chk({nm, "_r"},     32'(bus.remainder_out), 32'(r));
        chk({nm, "_dbz"},   32'(bus.div_by_zero), 32'(dbz));
    endtask

    task automatic check_reset_outputs(input string nm);
        chk({nm, "_resp_valid"}, 32'(bus.resp_valid), 0);
        chk({nm, "_quotient"},   32'(bus.quotient_out), 0);
        chk({nm, "_remainder"},  32'(bus.remainder_out), 0);
        chk({nm, "_dbz"},        32'(bus.div_by_zero), 0);
        chk({nm, "_busy"},       32'(bus.busy), 0);
        chk({nm, "_grant"},      32'(bus.grant_id), 0);
        chk({nm, "_div_go"},     32'(bus.div_go), 0);
        chk({nm, "_div_dvd"},    32'(bus.div_dividend), 0);
        chk({nm, "_div_dvs"},    32'(bus.div_divisor), 0);
    endtask

    function automatic logic [40:0] outs();
        return {bus.resp_valid, bus.quotient_out, bus.remainder_out, bus.div_by_zero, bus.busy,
                bus.grant_id, bus.div_go, bus.div_dividend, bus.div_divisor};
    endfunction

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int lat, gocnt, cyc, w, ptr_m;
        logic bad;
        logic [40:0] snap;
        logic [NREQ-1:0] pend;
        logic [7:0] m_dvd [NREQ];
        logic [7:0] m_dvs [NREQ];
        logic [7:0] eq [4];
        logic [7:0] er [4];

        tbl[0] = '{2, 8'd100, 8'd7,   8'd14,  8'd2,  1'b0, 12, 10};
        tbl[1] = '{1, 8'd55,  8'd0,   8'hFF,  8'd55, 1'b1, 1,  0};
        tbl[2] = '{3, 8'd81,  8'd9,   8'd9,   8'd0,  1'b0, 12, 10};
        tbl[3] = '{0, 8'd255, 8'd16,  8'd15,  8'd15, 1'b0, 12, 10};
        tbl[4] = '{1, 8'd200, 8'd3,   8'd66,  8'd2,  1'b0, 12, 10};
        tbl[5] = '{2, 8'd7,   8'd100, 8'd0,   8'd7,  1'b0, 12, 10};
        tbl[6] = '{3, 8'd255, 8'd1,   8'd255, 8'd0,  1'b0, 12, 10};
        tbl[7] = '{0, 8'd0,   8'd0,   8'hFF,  8'd0,  1'b1, 1,  0};
        tbl[8] = '{0, 8'd0,   8'd5,   8'd0,   8'd0,  1'b0, 12, 10};
        tbl[9] = '{3, 8'd255, 8'd255, 8'd1,   8'd0,  1'b0, 12, 10};

        reset           = 1'b1;
        clken           = 1'b1;
        bus.req         = '0;
        bus.dividend_in = '0;
        bus.divisor_in  = '0;
        tick();
        tick();
        check_reset_outputs("reset");
        reset = 1'b0;

        // All requesters continuously asserted: service order 0,1,2,3.
        set_op(0, 8'd200, 8'd3);
        set_op(1, 8'd9,   8'd9);
        set_op(2, 8'd255, 8'd16);
        set_op(3, 8'd0,   8'd5);
        eq = '{8'd66, 8'd1, 8'd15, 8'd0};
        er = '{8'd2,  8'd0, 8'd15, 8'd0};
        bus.req = 4'b1111;
        for (int i = 0; i < 4; i++) begin
            wait_resp(lat, gocnt);
            check_result($sformatf("all4_%0d", i), i, eq[i], er[i], 1'b0, (i == 0) ? 12 : 13, lat);
            if (i == 3) bus.req = '0;
        end
        tick();

        // Table of single-requester operations.
        for (int i = 0; i < 10; i++) begin
            set_op(tbl[i].k, tbl[i].dvd, tbl[i].dvs);
            bus.req[tbl[i].k] = 1'b1;
            wait_resp(lat, gocnt);
            check_result($sformatf("vec%0d", i), tbl[i].k, tbl[i].q, tbl[i].r, tbl[i].dbz, tbl[i].lat, lat);
            chk($sformatf("vec%0d_go_cycles", i), 32'(gocnt), 32'(tbl[i].go));
            bus.req = '0;
            tick();
            chk($sformatf("vec%0d_strobe_off", i), 32'(bus.resp_valid), 0);
            chk($sformatf("vec%0d_idle", i), 32'(bus.busy), 0);
            chk($sformatf("vec%0d_hold_q", i), 32'(bus.quotient_out), 32'(tbl[i].q));
            chk($sformatf("vec%0d_hold_r", i), 32'(bus.remainder_out), 32'(tbl[i].r));
        end

        // Serve requester 1 so the pointer sits at 2, then req=0011 wraps to 0 first.
        set_op(1, 8'd30, 8'd4);
        bus.req = 4'b0010;
        wait_resp(lat, gocnt);
        check_result("ptr_setup", 1, 8'd7, 8'd2, 1'b0, 12, lat);
        bus.req = '0;
        tick();
        set_op(0, 8'd90, 8'd10);
        set_op(1, 8'd17, 8'd5);
        bus.req = 4'b0011;
        wait_resp(lat, gocnt);
        check_result("ptr_wrap_first", 0, 8'd9, 8'd0, 1'b0, 12, lat);
        bus.req[0] = 1'b0;
        wait_resp(lat, gocnt);
        check_result("ptr_wrap_second", 1, 8'd3, 8'd2, 1'b0, 13, lat);
        bus.req = '0;
        tick();

        // Clock enable toggling every cycle, starting with a disabled cycle.
        set_op(2, 8'd100, 8'd7);
        bus.req = 4'b0100;
        clken   = 1'b0;
        cyc     = 0;
        bad     = 1'b0;
        do begin
            snap = outs();
            w    = clken ? 0 : 1;
            tick();
            cyc++;
            if (w == 1 && outs() !== snap) bad = 1'b1;
            clken = (cyc % 2 == 1);
        end while (bus.resp_valid === '0 && cyc < 100);
        check_result("clken", 2, 8'd14, 8'd2, 1'b0, 24, cyc);
        snap = outs();
        tick();
        if (outs() !== snap) bad = 1'b1;
        chk("clken_resp_held", 32'(bus.resp_valid), 32'(4'b0100));
        clken   = 1'b1;
        bus.req = '0;
        tick();
        chk("clken_strobe_off", 32'(bus.resp_valid), 0);
        chk("clken_hold_on_disabled_edges", 32'(bad), 0);

        // Reset in the middle of GO, then serve from pointer 0.
        set_op(2, 8'd100, 8'd7);
        bus.req = 4'b0100;
        for (int i = 0; i < 4; i++) tick();
        chk("rst_pre_go", 32'(bus.div_go), 1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("rst_mid");
        @(posedge clk);
        #1;
        bus.req = '0;
        reset   = 1'b0;
        set_op(0, 8'd81, 8'd9);
        set_op(3, 8'd50, 8'd7);
        bus.req = 4'b1001;
        wait_resp(lat, gocnt);
        check_result("post_rst_first", 0, 8'd9, 8'd0, 1'b0, 12, lat);
        bus.req[0] = 1'b0;
        wait_resp(lat, gocnt);
        check_result("post_rst_second", 3, 8'd7, 8'd1, 1'b0, 13, lat);
        bus.req = '0;
        tick();

        // Randomized traffic against a round-robin reference model.
        ptr_m = 0;
        pend  = '0;
        for (int k = 0; k < NREQ; k++) begin
            m_dvd[k] = '0;
            m_dvs[k] = '0;
        end
        for (int it = 0; it < 40; it++) begin
            for (int k = 0; k < NREQ; k++) begin
                if (!pend[k] && $urandom_range(1, 0) == 1) begin
                    pend[k]  = 1'b1;
                    m_dvd[k] = 8'($urandom_range(255, 0));
                    if ($urandom_range(5, 0) == 0)      m_dvs[k] = 8'd0;
                    else if ($urandom_range(1, 0) == 0) m_dvs[k] = 8'($urandom_range(15, 1));
                    else                                m_dvs[k] = 8'($urandom_range(255, 1));
                end
            end
            if (pend == '0) begin
                w        = int'($urandom_range(NREQ - 1, 0));
                pend[w]  = 1'b1;
                m_dvd[w] = 8'($urandom_range(255, 0));
                m_dvs[w] = 8'($urandom_range(255, 1));
            end
            for (int k = 0; k < NREQ; k++) set_op(k, m_dvd[k], m_dvs[k]);
            bus.req = pend;
            w = -1;
            for (int i = 0; i < NREQ; i++) begin
                if (w < 0 && pend[(ptr_m + i) % NREQ]) w = (ptr_m + i) % NREQ;
            end
            wait_resp(lat, gocnt);
            check_result($sformatf("rand%0d", it), w,
                         (m_dvs[w] == 0) ? 8'hFF : m_dvd[w] / m_dvs[w],
                         (m_dvs[w] == 0) ? m_dvd[w] : m_dvd[w] % m_dvs[w],
                         (m_dvs[w] == 0), (m_dvs[w] == 0) ? 1 : 12, lat);
            pend[w] = 1'b0;
            bus.req = pend;
            ptr_m   = (w + 1) % NREQ;
            tick();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end
endmodule
